fgpu_line_reader: RTL and testbench

//  Streaming cache-line read engine inside app_afu, directly downstream of the MPF "afu" port.

---
 rtl/fgpu_reader_pkg.sv | 18 +
 rtl/fgpu_line_reader.sv | 132 +++++++++++++
 tb/tb_fgpu_line_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fgpu_reader_pkg.sv
// Shared types and constants for the FGPU streaming cache-line reader.
package fgpu_reader_pkg;

  localparam int unsigned C_LINE_BITS   = 512;
  localparam int unsigned C_LINE_ADDR_W = 42;
  localparam int unsigned C_LEN_W       = 32;

  typedef logic [C_LINE_ADDR_W-1:0] t_line_addr;
  typedef logic [C_LEN_W-1:0]       t_line_idx;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } t_reader_state;

endpackage

// File: rtl/fgpu_line_reader.sv
// Streaming cache-line read engine: issues RdLine requests on CCI-P c0 Tx and
// forwards each tagged read response to the FGPU compute core.
module fgpu_line_reader
  import fgpu_reader_pkg::*;
#(
  parameter int unsigned LINE_ADDR_W     = C_LINE_ADDR_W,
  parameter int unsigned LEN_W           = C_LEN_W,
  parameter int unsigned MDATA_W         = 16,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LINE_ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]       num_lines,
  output logic                   busy,
  output logic                   done,
  output logic                   err_unexpected,
  input  logic                   c0TxAlmFull,
  output logic                   c0Tx_valid,
  output logic [LINE_ADDR_W-1:0] c0Tx_addr,
  output logic [MDATA_W-1:0]     c0Tx_mdata,
  input  logic                   c0Rx_rdValid,
  input  logic [MDATA_W-1:0]     c0Rx_mdata,
  input  logic [C_LINE_BITS-1:0] c0Rx_data,
  output logic                   out_valid,
  output logic [MDATA_W-1:0]     out_idx,
  output logic [C_LINE_BITS-1:0] out_data
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  t_reader_state          state_q, state_d;
  logic [LINE_ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]       num_q, issued_q, received_q;
  logic [OUT_W-1:0]       outstanding_q;
  logic                   done_q;

  logic                   accept, fire, rsp;
  logic [LINE_ADDR_W-1:0] cur_base;
  logic [LEN_W-1:0]       cur_num, cur_issued, received_nxt;

  // The first request is decided in the same cycle start is accepted, straight
  // from the input operands, so it lands one cycle after start.
  always_comb begin
    accept       = (state_q == IDLE) && !done_q && start;
    rsp          = c0Rx_rdValid && (state_q != IDLE);
    cur_base     = accept ? base_addr : base_q;
    cur_num      = accept ? num_lines : num_q;
    cur_issued   = accept ? '0 : issued_q;
    fire         = (accept || (state_q == ISSUE)) && !c0TxAlmFull &&
                   (outstanding_q < OUT_W'(MAX_OUTSTANDING)) &&
                   (cur_issued < cur_num);
    received_nxt = received_q + LEN_W'(rsp);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (num_lines == '0) ? DONE : ISSUE;
      ISSUE:   if (issued_q == num_q) state_d = DRAIN;
      // Looking at the response being accepted now lets done follow the last out_valid directly.
      DRAIN:   if (received_nxt == num_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      base_q         <= '0;
      num_q          <= '0;
      issued_q       <= '0;
      received_q     <= '0;
      outstanding_q  <= '0;
      done_q         <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      if (accept) begin
        base_q     <= base_addr;
        num_q      <= num_lines;
        issued_q   <= LEN_W'(fire);
        received_q <= '0;
      end else begin
        if (fire) issued_q <= issued_q + LEN_W'(1);
        if (rsp)  received_q <= received_nxt;
      end
      case ({fire, rsp})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      if (c0Rx_rdValid && (state_q == IDLE)) err_unexpected <= 1'b1;
      else if (accept)                       err_unexpected <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0Tx_valid <= 1'b0;
      c0Tx_addr  <= '0;
      c0Tx_mdata <= '0;
    end else begin
      c0Tx_valid <= fire;
      if (fire) begin
        c0Tx_addr  <= cur_base + LINE_ADDR_W'(cur_issued);
        c0Tx_mdata <= MDATA_W'(cur_issued);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= rsp;
      if (rsp) begin
        out_idx  <= c0Rx_mdata;
        out_data <= c0Rx_data;
      end
    end
  end

  assign busy = (state_q != IDLE) || done_q;
  assign done = done_q;

endmodule

// File: tb/tb_fgpu_line_reader.sv
// Directed bench for fgpu_line_reader with a delayed echo responder on c0 Rx.
module tb_fgpu_line_reader;

  localparam int unsigned LA   = 42;
  localparam int unsigned LW   = 32;
  localparam int unsigned MW   = 16;
  localparam int unsigned MAXO = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [LA-1:0] base_addr = '0;
  logic [LW-1:0] num_lines = '0;
  logic          busy, done, err_unexpected;
  logic          c0TxAlmFull = 1'b0;
  logic          c0Tx_valid;
  logic [LA-1:0] c0Tx_addr;
  logic [MW-1:0] c0Tx_mdata;
  logic          c0Rx_rdValid = 1'b0;
  logic [MW-1:0] c0Rx_mdata = '0;
  logic [511:0]  c0Rx_data = '0;
  logic          out_valid;
  logic [MW-1:0] out_idx;
  logic [511:0]  out_data;

  fgpu_line_reader #(
    .LINE_ADDR_W(LA), .LEN_W(LW), .MDATA_W(MW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .busy(busy), .done(done), .err_unexpected(err_unexpected),
    .c0TxAlmFull(c0TxAlmFull), .c0Tx_valid(c0Tx_valid), .c0Tx_addr(c0Tx_addr),
    .c0Tx_mdata(c0Tx_mdata), .c0Rx_rdValid(c0Rx_rdValid), .c0Rx_mdata(c0Rx_mdata),
    .c0Rx_data(c0Rx_data), .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] line_data(input logic [LA-1:0] a);
    logic [31:0] w;
    w = a[31:0] ^ 32'hC0DE_0000;
    return {16{w}};
  endfunction

  typedef struct {
    logic [MW-1:0] md;
    logic [LA-1:0] addr;
    int unsigned   due;
  } pend_t;

  pend_t         pend[$];
  logic [LA-1:0] tx_addr[$];
  logic [MW-1:0] tx_md[$];
  int unsigned   tx_cyc[$];
  logic [MW-1:0] ov_idx[$];
  logic [511:0]  ov_data[$];
  int unsigned   ov_cyc[$];
  int unsigned   done_cyc[$];
  int unsigned   cyc = 0;
  int unsigned   inflight = 0;
  int unsigned   rsp_delay = 5;
  bit            hold = 1'b0;

  // Monitor and memory model: record Tx/out/done, answer requests after rsp_delay cycles.
  always @(negedge clk) begin
    pend_t p;
    cyc++;
    if (c0Tx_valid) begin
      tx_addr.push_back(c0Tx_addr);
      tx_md.push_back(c0Tx_mdata);
      tx_cyc.push_back(cyc);
      pend.push_back('{c0Tx_mdata, c0Tx_addr, cyc + rsp_delay});
    end
    if (out_valid) begin
      ov_idx.push_back(out_idx);
      ov_data.push_back(out_data);
      ov_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      c0Rx_rdValid = 1'b1;
      c0Rx_mdata   = p.md;
      c0Rx_data    = line_data(p.addr);
    end else begin
      c0Rx_rdValid = 1'b0;
    end
    inflight = pend.size();
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_xfer(input logic [LA-1:0] b, input logic [LW-1:0] n, output int unsigned t);
    base_addr = b;
    num_lines = n;
    start     = 1'b1;
    t         = cyc;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget, output int unsigned max_inf);
    int unsigned d0, k;
    d0 = done_cyc.size();
    k = 0;
    max_inf = 0;
    while (done_cyc.size() == d0 && k < budget) begin
      tick(1);
      if (inflight > max_inf) max_inf = inflight;
      k++;
    end
    check(tag, done_cyc.size() > d0, 1'b1);
  endtask

  // Runs a transfer to completion and checks every address, tag, payload and order.
  task automatic run_and_check(input string tag, input logic [LA-1:0] b, input int unsigned n);
    int unsigned t, i0, o0, d0, mx, bad;
    logic [LA-1:0] ea;
    i0 = tx_addr.size(); o0 = ov_idx.size(); d0 = done_cyc.size();
    start_xfer(b, LW'(n), t);
    wait_done({tag, "_done"}, 2000, mx);
    tick(2);
    check({tag, "_ntx"}, tx_addr.size() - i0, n);
    check({tag, "_nout"}, ov_idx.size() - o0, n);
    check({tag, "_ndone"}, done_cyc.size() - d0, 1);
    bad = 0;
    for (int unsigned i = 0; i < n && i0 + i < tx_addr.size() && o0 + i < ov_idx.size(); i++) begin
      ea = b + LA'(i);
      if (tx_addr[i0+i] !== ea || tx_md[i0+i] !== MW'(i)) bad++;
      if (ov_idx[o0+i] !== MW'(i) || ov_data[o0+i] !== line_data(ea)) bad++;
    end
    check({tag, "_bad"}, bad, 0);
    if (ov_cyc.size() > o0 && done_cyc.size() > d0)
      check({tag, "_done_cyc"}, done_cyc[d0], ov_cyc[ov_cyc.size()-1] + 1);
  endtask

  initial begin
    int unsigned t, i0, o0, d0, mx, a, cnt_hole, cnt_at_a, cnt_after, k;

    // Reset state
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_unexpected, 0);
    check("rst_txv", c0Tx_valid, 0);
    check("rst_outv", out_valid, 0);
    reset_n = 1'b1;
    tick(2);

    // 1: four lines, 5-cycle echo, back-to-back issue right after start
    i0 = tx_addr.size();
    run_and_check("t1", 42'h1000, 4);
    for (int unsigned i = 0; i < 4; i++) begin
      check("t1_addr", tx_addr[i0+i], 42'h1000 + 42'(i));
      check("t1_txcyc", tx_cyc[i0+i], tx_cyc[i0] + i);
    end

    // 1b: address wraps at LINE_ADDR_W
    i0 = tx_addr.size();
    run_and_check("t1b", 42'h3FF_FFFF_FFFE, 3);
    check("t1b_wrap", tx_addr[i0+2], 42'h0);

    // start-to-first-request latency
    i0 = tx_addr.size();
    start_xfer(42'h1800, 1, t);
    wait_done("lat_done", 200, mx);
    check("lat_first", tx_cyc[i0], t + 1);
    tick(2);

    // 2: outstanding cap with the responder withholding everything
    hold = 1'b1;
    i0 = tx_addr.size(); o0 = ov_idx.size(); d0 = done_cyc.size();
    start_xfer(42'h2000, 200, t);
    tick(100);
    check("t2_cap", tx_addr.size() - i0, MAXO);
    check("t2_busy", busy, 1);
    tick(10);
    check("t2_stall", tx_addr.size() - i0, MAXO);
    hold = 1'b0;
    wait_done("t2_done", 3000, mx);
    tick(2);
    check("t2_ntx", tx_addr.size() - i0, 200);
    check("t2_nout", ov_idx.size() - o0, 200);
    k = 0;
    for (int unsigned i = 0; i < 200 && o0 + i < ov_idx.size(); i++)
      if (ov_idx[o0+i] !== MW'(i)) k++;
    check("t2_order", k, 0);

    // 3: AlmFull held for 10 cycles mid-ISSUE
    i0 = tx_addr.size();
    start_xfer(42'h3000, 40, t);
    tick(4);
    a = cyc;
    c0TxAlmFull = 1'b1;
    tick(10);
    c0TxAlmFull = 1'b0;
    wait_done("t3_done", 2000, mx);
    tick(2);
    cnt_hole = 0; cnt_at_a = 0; cnt_after = 0;
    for (int unsigned i = i0; i < tx_cyc.size(); i++) begin
      if (tx_cyc[i] > a && tx_cyc[i] <= a + 10) cnt_hole++;
      if (tx_cyc[i] == a) cnt_at_a++;
      if (tx_cyc[i] == a + 11) cnt_after++;
    end
    check("t3_hole", cnt_hole, 0);
    check("t3_inflight", cnt_at_a, 1);
    check("t3_resume", cnt_after, 1);
    check("t3_ntx", tx_addr.size() - i0, 40);

    // 4: zero-length transfer
    i0 = tx_addr.size(); d0 = done_cyc.size();
    start_xfer(42'h4000, 0, t);
    check("t4_busy1", busy, 1);
    check("t4_done1", done, 0);
    tick(1);
    check("t4_busy2", busy, 1);
    check("t4_done2", done, 1);
    tick(1);
    check("t4_busy3", busy, 0);
    check("t4_done3", done, 0);
    tick(3);
    check("t4_ntx", tx_addr.size() - i0, 0);
    check("t4_ndone", done_cyc.size() - d0, 1);

    // 5: 1-cycle echo, issue and response overlap
    rsp_delay = 1;
    i0 = tx_addr.size(); o0 = ov_idx.size();
    start_xfer(42'h5000, 100, t);
    wait_done("t5_done", 2000, mx);
    tick(2);
    check("t5_outst", mx <= 2, 1);
    check("t5_nout", ov_idx.size() - o0, 100);
    k = 0;
    for (int unsigned i = 0; i < 100 && o0 + i < ov_idx.size(); i++)
      if (ov_idx[o0+i] !== MW'(i) || ov_data[o0+i] !== line_data(42'h5000 + 42'(i))) k++;
    check("t5_order", k, 0);
    check("t5_done_cyc", done_cyc[done_cyc.size()-1], ov_cyc[ov_cyc.size()-1] + 1);
    rsp_delay = 5;

    // 6: reset mid-DRAIN, then stray responses while IDLE
    hold = 1'b1;
    start_xfer(42'h6000, 20, t);
    tick(30);
    check("t6_busy_pre", busy, 1);
    d0 = done_cyc.size(); o0 = ov_idx.size();
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_txv", c0Tx_valid, 0);
    check("t6_rst_outv", out_valid, 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    hold = 1'b0;
    k = 0;
    while (pend.size() > 0 && k < 200) begin
      tick(1);
      k++;
    end
    tick(3);
    check("t6_drain", pend.size(), 0);
    check("t6_err", err_unexpected, 1);
    check("t6_nodone", done_cyc.size() - d0, 0);
    check("t6_nofwd", ov_idx.size() - o0, 0);
    check("t6_idle", busy, 0);
    o0 = ov_idx.size();
    start_xfer(42'h7000, 2, t);
    check("t6_errclr", err_unexpected, 0);
    wait_done("t6_done", 200, mx);
    tick(2);
    check("t6_nout", ov_idx.size() - o0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
